// File: rtl/masked_key_expander.sv
// Sequencer for a 3-share masked AES-128 key schedule: feeds RotWord(w3) shares to an
// external masked S-box column, folds the results back and streams round keys 0..10.
module masked_key_expander #(
    parameter int SBOX_LAT   = 4,
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key1,
    input  logic [127:0] key2,
    input  logic [127:0] key3,
    output logic         busy,
    output logic [31:0]  sb_in1,
    output logic [31:0]  sb_in2,
    output logic [31:0]  sb_in3,
    input  logic [31:0]  sb_out1,
    input  logic [31:0]  sb_out2,
    input  logic [31:0]  sb_out3,
    output logic         guards_mux_sel,
    output logic         guards_reg_en,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk1,
    output logic [127:0] rk2,
    output logic [127:0] rk3,
    output logic [3:0]   rk_round,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EMIT   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int              CNT_W    = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SBOX_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [3:0]      LAST_RND = 4'(NUM_ROUNDS);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // XOR-chain one share of the key state with its share of the transformed word
    function automatic logic [127:0] update_share(input logic [127:0] st, input logic [31:0] t);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        w0 = st[127:96] ^ t;
        w1 = st[95:64]  ^ w0;
        w2 = st[63:32]  ^ w1;
        w3 = st[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t           state_r, state_s;
    logic [127:0]     st1_r, st2_r, st3_r, st1_s, st2_s, st3_s;
    logic [31:0]      cap1_r, cap2_r, cap3_r, cap1_s, cap2_s, cap3_s;
    logic [7:0]       rcon_r, rcon_s;
    logic [3:0]       rnd_r, rnd_s;
    logic             first_r, first_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic             busy_r, busy_s, done_r, done_s, rk_valid_r, rk_valid_s;
    logic             mux_sel_r, mux_sel_s, reg_en_r, reg_en_s;
    logic [31:0]      sb_in1_r, sb_in2_r, sb_in3_r, sb_in1_s, sb_in2_s, sb_in3_s;
    logic [127:0]     rk1_r, rk2_r, rk3_r, rk1_s, rk2_s, rk3_s;
    logic [3:0]       rk_round_r, rk_round_s;

    // Next-state and datapath-register logic
    always_comb begin
        state_s = state_r;
        st1_s   = st1_r;
        st2_s   = st2_r;
        st3_s   = st3_r;
        cap1_s  = cap1_r;
        cap2_s  = cap2_r;
        cap3_s  = cap3_r;
        rcon_s  = rcon_r;
        rnd_s   = rnd_r;
        first_s = first_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    st1_s   = key1;
                    st2_s   = key2;
                    st3_s   = key3;
                    rcon_s  = 8'h01;
                    rnd_s   = 4'd0;
                    first_s = 1'b1;
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    state_s = (rnd_r == LAST_RND) ? ST_DONE : ST_ISSUE;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_ISSUE: begin
                first_s = 1'b0;
                cnt_s   = CNT_LOAD;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    cap1_s  = sb_out1;
                    cap2_s  = sb_out2;
                    cap3_s  = sb_out3;
                    state_s = ST_UPDATE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_UPDATE: begin
                // Rcon enters share 1 only; shares never mix
                st1_s   = update_share(st1_r, cap1_r ^ {rcon_r, 24'h000000});
                st2_s   = update_share(st2_r, cap2_r);
                st3_s   = update_share(st3_r, cap3_r);
                rcon_s  = xtime(rcon_r);
                rnd_s   = rnd_r + 4'd1;
                state_s = ST_EMIT;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values decoded from the upcoming state so every port is driven by a flop
    always_comb begin
        busy_s     = 1'b0;
        done_s     = 1'b0;
        rk_valid_s = 1'b0;
        mux_sel_s  = 1'b0;
        reg_en_s   = 1'b0;
        sb_in1_s   = sb_in1_r;
        sb_in2_s   = sb_in2_r;
        sb_in3_s   = sb_in3_r;
        rk1_s      = rk1_r;
        rk2_s      = rk2_r;
        rk3_s      = rk3_r;
        rk_round_s = rk_round_r;
        case (state_s)
            ST_EMIT: begin
                busy_s     = 1'b1;
                rk_valid_s = 1'b1;
                rk1_s      = st1_s;
                rk2_s      = st2_s;
                rk3_s      = st3_s;
                rk_round_s = rnd_s;
            end
            ST_ISSUE: begin
                busy_s    = 1'b1;
                reg_en_s  = 1'b1;
                mux_sel_s = first_r;
                sb_in1_s  = rot_word(st1_s[31:0]);
                sb_in2_s  = rot_word(st2_s[31:0]);
                sb_in3_s  = rot_word(st3_s[31:0]);
            end
            ST_WAIT, ST_UPDATE: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, key-state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            st1_r      <= 128'd0;
            st2_r      <= 128'd0;
            st3_r      <= 128'd0;
            cap1_r     <= 32'd0;
            cap2_r     <= 32'd0;
            cap3_r     <= 32'd0;
            rcon_r     <= 8'h01;
            rnd_r      <= 4'd0;
            first_r    <= 1'b0;
            cnt_r      <= CNT_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rk_valid_r <= 1'b0;
            mux_sel_r  <= 1'b0;
            reg_en_r   <= 1'b0;
            sb_in1_r   <= 32'd0;
            sb_in2_r   <= 32'd0;
            sb_in3_r   <= 32'd0;
            rk1_r      <= 128'd0;
            rk2_r      <= 128'd0;
            rk3_r      <= 128'd0;
            rk_round_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            st1_r      <= st1_s;
            st2_r      <= st2_s;
            st3_r      <= st3_s;
            cap1_r     <= cap1_s;
            cap2_r     <= cap2_s;
            cap3_r     <= cap3_s;
            rcon_r     <= rcon_s;
            rnd_r      <= rnd_s;
            first_r    <= first_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            rk_valid_r <= rk_valid_s;
            mux_sel_r  <= mux_sel_s;
            reg_en_r   <= reg_en_s;
            sb_in1_r   <= sb_in1_s;
            sb_in2_r   <= sb_in2_s;
            sb_in3_r   <= sb_in3_s;
            rk1_r      <= rk1_s;
            rk2_r      <= rk2_s;
            rk3_r      <= rk3_s;
            rk_round_r <= rk_round_s;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign rk_valid       = rk_valid_r;
    assign guards_mux_sel = mux_sel_r;
    assign guards_reg_en  = reg_en_r;
    assign sb_in1         = sb_in1_r;
    assign sb_in2         = sb_in2_r;
    assign sb_in3         = sb_in3_r;
    assign rk1            = rk1_r;
    assign rk2            = rk2_r;
    assign rk3            = rk3_r;
    assign rk_round       = rk_round_r;

endmodule

// File: doc/masked_key_expander.md
Name: masked_key_expander

Overview:
- Sequencer that drives the 4-byte masked (3-share, second-order) key-schedule S-box column and consumes its results.
- Holds the 3-share AES-128 key state and issues RotWord(w3) shares to the column.
- Applies Rcon and XOR-chains the new words, then streams the 11 round keys (rounds 0..10) in shares to the datapath over a valid/ready handshake.
- Owns the column's guard control: fresh-guard select on first use, guard-register enable on every issue.

Parameters:
- SBOX_LAT, 4, cycles from S-box column input applied to shared output valid; must be ≥1
- NUM_ROUNDS, 10, number of expanded round keys after round 0 (AES-128)

Ports:
- clk  in  1  clock (single clock domain)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; loads key shares when idle
- key1/key2/key3  in  128  key shares; key = key1^key2^key3, w0 = [127:96]
- busy  out  1  high from start accepted until done
- sb_in1/sb_in2/sb_in3  out  32  shares of RotWord(w3) to the S-box column
- sb_out1/sb_out2/sb_out3  in  32  shared SubWord result from the column
- guards_mux_sel  out  1  1 = column takes fresh external guards; 0 = registered guards
- guards_reg_en  out  1  column guard-register load enable
- rk_valid  out  1  round-key shares valid
- rk_ready  in  1  consumer accepts the round key
- rk1/rk2/rk3  out  128  round-key shares
- rk_round  out  4  index (0..10) of the key on rk*
- done  out  1  one-cycle pulse after round NUM_ROUNDS is accepted

Behaviour:
- Reset (async assert, sync release) clears all outputs and registers to 0, sets FSM to IDLE, sets Rcon to 8'h01, and clears the first-issue flag.
- FSM states:
  - IDLE: start=1 → latch key shares into st1..st3, rcon=01, rnd=0, first=1, busy=1 → EMIT. start is ignored in every other state.
  - EMIT: rk_valid=1, rk*=st*, rk_round=rnd. On rk_valid&rk_ready:
    - if rnd==NUM_ROUNDS → DONE
    - else → ISSUE
    - rk* stay stable while stalled.
  - ISSUE (1 cycle):
    - sb_in* = {w3[23:0],w3[31:24]} per share; registered, so they hold from this cycle through WAIT.
    - guards_reg_en=1.
    - guards_mux_sel=first; first is then cleared.
    - cnt=SBOX_LAT-1 → WAIT.
  - WAIT: cnt decrements. At cnt==0, capture sb_out* and go to UPDATE. With SBOX_LAT==1, WAIT captures in its first cycle.
  - UPDATE (1 cycle), per share s:
    - t_s = sb_out_s, with share 1 only also XORed with {rcon,24'h0}
    - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
    - rcon=xtime(rcon) (01,02,…,80,1b,36)
    - rnd+=1 → EMIT
  - DONE: done=1 for one cycle, busy=0, rk_valid=0 → IDLE.
- Shares are never combined. Rcon touches share 1 only. No share is ever XORed with another share.
- guards_mux_sel is 0 except in the first ISSUE after each start. guards_reg_en is 1 only in ISSUE.
- sb_in* hold their last value outside ISSUE/WAIT; they are not forced to 0, to avoid unmasked glitches.
- Throughput per round: 1 (EMIT, zero stall) + 1 (ISSUE) + SBOX_LAT (WAIT) + 1 (UPDATE) cycles.
- Reset mid-operation aborts immediately. No done pulse is produced, and the next start restarts from round 0 with fresh guards.
- rk_ready held low stalls indefinitely in EMIT with no state change.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, random key2/key3, behavioral S-box column with SBOX_LAT=4, rk_ready=1:
  - XOR of shares rk_round=1 → a0fafe1788542cb123a339392a6c7605
  - rk_round=10 → d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses once, and busy falls with it.
- Same key with key2=key3=0 versus random shares → identical unmasked round keys; rk2/rk3 differ between runs.
- Guard control: guards_mux_sel=1 only in the first ISSUE; guards_reg_en pulses exactly 10 times per expansion; a second start gets mux_sel=1 again.
- Backpressure: rk_ready=0 for 7 cycles at rk_round=3 → rk* and rk_round stable, no ISSUE until ready; final keys unchanged.
- Timing: SBOX_LAT=1 and SBOX_LAT=6 → ISSUE-to-capture gap equals SBOX_LAT; round 10 key still correct.
- rst_n low during WAIT of round 5 → outputs 0 immediately, no done; restart yields correct round 0..10 sequence. start pulsed while busy → ignored.
